// File: rtl/arbiter_x4_pkg.sv
// Shared constants and types for the four-way round-robin arbiter.
// Both the arbiter and its bench import this package.
package arbiter_x4_pkg;

   localparam int N_REQ        = 4;
   localparam int MAX_HOLD_DEF = 8;
   localparam int CNT_W        = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic [3:0] onehot4(input logic [1:0] id);
      return 4'b0001 << id;
   endfunction

endpackage

// File: rtl/arbiter_x4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface arbiter_x4_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       preempt;

   modport master (output req, input gnt, gnt_id, gnt_valid, preempt);
   modport slave  (input req, output gnt, gnt_id, gnt_valid, preempt);
endinterface

// File: rtl/arbiter_x4_rr_pick.sv
// Combinational round-robin search: the first unmasked request at or after
// i_start, wrapping, wins.
module rr_pick_x4 (
   input  logic [3:0] i_req,
   input  logic [1:0] i_start,
   input  logic [3:0] i_excl,
   output logic [1:0] o_winner,
   output logic       o_found
);

   logic [3:0] w_masked;
   logic [1:0] w_idx;
   logic       w_hit;

   assign w_masked = i_req & ~i_excl;

   // Scan four positions from i_start; the first hit locks the winner.
   always_comb begin
      o_found  = 1'b0;
      o_winner = i_start;
      w_idx    = i_start;
      w_hit    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w_idx    = i_start + 2'(i);
         w_hit    = !o_found && w_masked[w_idx];
         o_winner = w_hit ? w_idx : o_winner;
         o_found  = o_found | w_hit;
      end
   end

endmodule

// File: rtl/arbiter_x4.sv
// Four-requester round-robin arbiter with a hold limit that forces a hand-off
// when another requester has been waiting MAX_HOLD cycles.
module arbiter_x4
   import arbiter_x4_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   arbiter_x4_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

   state_t           r_state;
   logic [3:0]       r_gnt;
   logic [1:0]       r_gnt_id;
   logic             r_gnt_valid;
   logic             r_preempt;
   logic [1:0]       r_last_id;
   logic [CNT_W-1:0] r_cnt;

   logic [1:0]       w_start;
   logic [3:0]       w_excl;
   logic [1:0]       w_winner;
   logic             w_found;
   logic             w_held;

   // While busy the current holder is masked out; on a release its bit is already zero.
   assign w_start = r_last_id + 2'd1;
   assign w_excl  = (r_state == ST_BUSY) ? onehot4(r_gnt_id) : 4'b0000;
   assign w_held  = bus.req[r_gnt_id];

   rr_pick_x4 u_pick (
      .i_req    (bus.req),
      .i_start  (w_start),
      .i_excl   (w_excl),
      .o_winner (w_winner),
      .o_found  (w_found)
   );

   // Arbitration state machine; every output is a register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_gnt       <= 4'b0000;
         r_gnt_id    <= 2'b00;
         r_gnt_valid <= 1'b0;
         r_preempt   <= 1'b0;
         r_last_id   <= 2'd3;
         r_cnt       <= '0;
      end else begin
         r_preempt <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_state     <= ST_BUSY;
                  r_gnt       <= onehot4(w_winner);
                  r_gnt_id    <= w_winner;
                  r_gnt_valid <= 1'b1;
                  r_last_id   <= w_winner;
                  r_cnt       <= '0;
               end else begin
                  r_gnt       <= 4'b0000;
                  r_gnt_valid <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (!w_held || (r_cnt == CNT_MAX && w_found)) begin
                  if (w_found) begin
                     r_gnt       <= onehot4(w_winner);
                     r_gnt_id    <= w_winner;
                     r_gnt_valid <= 1'b1;
                     r_last_id   <= w_winner;
                     r_cnt       <= '0;
                     r_preempt   <= w_held;
                  end else begin
                     r_state     <= ST_IDLE;
                     r_gnt       <= 4'b0000;
                     r_gnt_id    <= 2'b00;
                     r_gnt_valid <= 1'b0;
                     r_cnt       <= '0;
                  end
               end else if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + 8'd1;
               end else begin
                  r_cnt <= r_cnt;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_gnt       <= 4'b0000;
               r_gnt_id    <= 2'b00;
               r_gnt_valid <= 1'b0;
               r_cnt       <= '0;
            end
         endcase
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.gnt_id    = r_gnt_id;
   assign bus.gnt_valid = r_gnt_valid;
   assign bus.preempt   = r_preempt;

endmodule

// File: doc/arbiter_x4.md
ARBITER_X4 -- requirements
Module: arbiter_x4

Interface
REQ-001 Parameter MAX_HOLD, default 8, SHALL set the maximum consecutive grant cycles while another requester waits (legal 2..255).
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 req  input  4  request lines, bit i = requester i, level-sensitive.
REQ-005 gnt  output  4  one-hot grant, registered; all-zero when idle.
REQ-006 gnt_id  output  2  binary index of granted requester, registered; valid only when gnt_valid=1.
REQ-007 gnt_valid  output  1  registered; 1 exactly when gnt is non-zero.
REQ-008 preempt  output  1  registered single-cycle pulse marking a forced hand-off by hold limit.

Function
REQ-009 States SHALL be IDLE (no grant) and BUSY (one grant active); gnt SHALL never have more than one bit set.
REQ-010 Winner selection SHALL be round-robin: search order starts at (last_id+1) mod 4 and wraps, first set bit wins.
REQ-011 last_id SHALL update to the winner on every new grant, including hand-offs.
REQ-012 IDLE with req!=0 at edge n: SHALL enter BUSY with gnt set to the winner at edge n (visible cycle n+1); latency one cycle.
REQ-013 IDLE with req==0: SHALL stay IDLE, outputs unchanged at zero.
REQ-014 BUSY, req[gnt_id]=1, hold limit not hit: grant SHALL be held unchanged.
REQ-015 BUSY, req[gnt_id]=0 (release): at that edge the arbiter SHALL grant the round-robin winner among remaining requests with no dead cycle, or go IDLE if none remain.
REQ-016 Hold counter SHALL clear to 0 on every new grant and increment each BUSY cycle, saturating at MAX_HOLD-1.
REQ-017 BUSY with counter==MAX_HOLD-1, req[gnt_id]=1 and any other req bit set: SHALL hand off to the round-robin winner excluding gnt_id and pulse preempt=1 for that one cycle.
REQ-018 BUSY with counter saturated and no other requester: grant SHALL be held indefinitely, no preempt.
REQ-019 Simultaneous release and limit on the same edge SHALL be treated as release (preempt=0).
REQ-020 A requester deasserting and reasserting while not granted SHALL have no effect beyond normal arbitration.

Reset
REQ-021 While rst_n=0 at an edge: gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, preempt=0, state=IDLE, counter=0, last_id=3 (requester 0 highest first).
REQ-022 Reset asserted mid-grant SHALL drop the grant at that edge; first arbitration after release uses last_id=3.
REQ-023 req SHALL be ignored on any edge where rst_n=0.

Structure
REQ-024 State encodings, requester count (4) and MAX_HOLD default SHALL live in a shared include/package file used by arbiter and bench.
REQ-025 Combinational round-robin search SHALL be one sub-module, rr_pick_x4 (inputs req[3:0], start[1:0], exclude mask; outputs winner id, found flag).
REQ-026 All outputs SHALL be driven directly from registers; no combinational path req->gnt.

Verification
REQ-027 Reset, then req=4'b1111 held -> grants 0,1,2,3,0 in order, each lasting MAX_HOLD=8 cycles, preempt pulse at every hand-off.
REQ-028 req=4'b0100 single cycle after reset -> gnt=4'b0100, gnt_id=2 next cycle; gnt=0 one cycle after req drops.
REQ-029 Requester 1 granted, req 1 drops while req=4'b1001 -> same edge grants requester 3 (search from 2), no idle cycle, preempt=0.
REQ-030 Only requester 2 held for 50 cycles -> gnt=4'b0100 continuous, preempt never asserts.
REQ-031 Requester 0 at counter=7, req[0]=0 and req[2]=1 same edge -> gnt=4'b0100, preempt=0.
REQ-032 rst_n=0 for one edge while gnt=4'b1000 -> next cycle all outputs zero; req=4'b1010 after release -> gnt=4'b0010.
